// File: rtl/sdram_cmd_monitor.sv
// Passive SDRAM command-bus monitor: checks power-up init, tRP/tRCD/tRFC,
// refresh interval and read-valid timing; reports sticky flags plus a pulse.
module sdram_cmd_monitor #(
  parameter int NUM_BANKS    = 4,
  parameter int ADDR_W       = 13,
  parameter int INIT_NOP_CYC = 100,
  parameter int INIT_REF_CNT = 2,
  parameter int TRP          = 3,
  parameter int TRCD         = 3,
  parameter int TRFC         = 7,
  parameter int TREFI_MAX    = 1560
) (
  input  logic                         sdram_clk,
  input  logic                         sdram_resetn,
  input  logic                         sdr_cs_n,
  input  logic                         sdr_ras_n,
  input  logic                         sdr_cas_n,
  input  logic                         sdr_we_n,
  input  logic [$clog2(NUM_BANKS)-1:0] sdr_ba,
  input  logic [ADDR_W-1:0]            sdr_addr,
  input  logic                         sdr_rd_valid,
  input  logic                         err_clr_i,
  output logic                         init_done_o,
  output logic [2:0]                   cl_o,
  output logic [3:0]                   bl_o,
  output logic [6:0]                   err_flags_o,
  output logic                         err_pulse_o,
  output logic [15:0]                  refresh_cnt_o
);

  localparam int unsigned NB     = NUM_BANKS;
  localparam int          BA_W   = $clog2(NUM_BANKS);
  localparam int          NOP_W  = $clog2(INIT_NOP_CYC + 1);
  localparam int          REF_W  = $clog2(INIT_REF_CNT + 1);
  localparam int          TRP_W  = $clog2(TRP + 1);
  localparam int          TRCD_W = $clog2(TRCD + 1);
  localparam int          TRFC_W = $clog2(TRFC + 1);
  localparam int          REFI_W = $clog2(TREFI_MAX + 2);
  localparam int          WIN_N  = 15;

  localparam logic [NOP_W-1:0]  NOP_L    = NOP_W'(INIT_NOP_CYC);
  localparam logic [REF_W-1:0]  REF_L    = REF_W'(INIT_REF_CNT);
  localparam logic [TRP_W-1:0]  TRP_L    = TRP_W'(TRP);
  localparam logic [TRCD_W-1:0] TRCD_L   = TRCD_W'(TRCD);
  localparam logic [TRFC_W-1:0] TRFC_L   = TRFC_W'(TRFC);
  localparam logic [REFI_W-1:0] REFI_LIM = REFI_W'(TREFI_MAX + 1);

  typedef enum logic [2:0] {C_NOP, C_ACT, C_RD, C_WR, C_PRE, C_REF, C_LMR, C_BST} cmd_t;
  typedef enum logic [1:0] {S_NOP, S_PRE, S_REF, S_RUN} state_t;

  cmd_t   cmd;
  state_t state_q, state_d;

  logic [NOP_W-1:0]  nop_cnt;
  logic [REF_W-1:0]  ref_cnt;
  logic [TRP_W-1:0]  trp_cnt;
  logic [TRFC_W-1:0] trfc_cnt;
  logic [TRCD_W-1:0] trcd_cnt [NUM_BANKS];
  logic [REFI_W-1:0] refi_cnt;
  logic [WIN_N-1:0]  pend_q, pend_vec, win_mask, hi_mask;

  logic       init_err, lmr_take, run_entry, rd_exp;
  logic       trp_err, trcd_err, trfc_err, refi_err, cl_err, rdv_err;
  logic [6:0] new_err;
  logic       a10;
  logic       unused_addr;

  assign a10         = sdr_addr[10];
  assign unused_addr = ^sdr_addr;

  always_comb begin
    cmd = C_NOP;
    if (!sdr_cs_n) begin
      case ({sdr_ras_n, sdr_cas_n, sdr_we_n})
        3'b011:  cmd = C_ACT;
        3'b101:  cmd = C_RD;
        3'b100:  cmd = C_WR;
        3'b010:  cmd = C_PRE;
        3'b001:  cmd = C_REF;
        3'b000:  cmd = C_LMR;
        3'b110:  cmd = C_BST;
        default: cmd = C_NOP;
      endcase
    end
  end

  always_ff @(posedge sdram_clk) begin
    if (!sdram_resetn) state_q <= S_NOP;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    init_err  = 1'b0;
    lmr_take  = 1'b0;
    run_entry = 1'b0;
    case (state_q)
      S_NOP: begin
        if (cmd != C_NOP)                  init_err = 1'b1;
        else if (nop_cnt >= NOP_L - 1'b1)  state_d  = S_PRE;
      end
      S_PRE: begin
        if (cmd == C_PRE && a10) state_d  = S_REF;
        else if (cmd != C_NOP)   init_err = 1'b1;
      end
      S_REF: begin
        if (cmd == C_LMR) begin
          if (ref_cnt >= REF_L) begin
            state_d   = S_RUN;
            lmr_take  = 1'b1;
            run_entry = 1'b1;
          end else begin
            init_err = 1'b1;
          end
        end else if (cmd != C_NOP && cmd != C_REF) begin
          init_err = 1'b1;
        end
      end
      S_RUN: lmr_take = (cmd == C_LMR);
      default: state_d = S_NOP;
    endcase
  end

  assign init_done_o = (state_q == S_RUN);

  // Expected-valid vector indexed by offset from the current edge: a READ
  // overwrites everything from its own CL onward, BURST TERM just clears it.
  always_comb begin
    for (int unsigned j = 0; j < WIN_N; j++) begin
      hi_mask[j]  = (j >= 32'(cl_o));
      win_mask[j] = (j >= 32'(cl_o)) && (j < 32'(cl_o) + 32'(bl_o));
    end
    pend_vec = pend_q;
    if (state_q == S_RUN) begin
      if (cmd == C_RD)       pend_vec = (pend_q & ~hi_mask) | win_mask;
      else if (cmd == C_BST) pend_vec = pend_q & ~hi_mask;
    end
    rd_exp = pend_vec[0];
  end

  always_comb begin
    trp_err  = (cmd == C_ACT || cmd == C_REF) && (trp_cnt < TRP_L);
    trcd_err = (cmd == C_RD || cmd == C_WR) && (trcd_cnt[sdr_ba] < TRCD_L);
    trfc_err = (cmd != C_NOP) && (trfc_cnt < TRFC_L);
    refi_err = (state_q == S_RUN) && (cmd != C_REF) && (refi_cnt == REFI_LIM - 1'b1);
    cl_err   = lmr_take && !(sdr_addr[6:4] == 3'd2 || sdr_addr[6:4] == 3'd3);
    rdv_err  = (state_q == S_RUN) && (sdr_rd_valid != rd_exp);
    new_err  = {rdv_err, cl_err, refi_err, trfc_err, trcd_err, trp_err, init_err};
  end

  always_ff @(posedge sdram_clk) begin
    if (!sdram_resetn) begin
      nop_cnt       <= '0;
      ref_cnt       <= '0;
      trp_cnt       <= TRP_L;
      trfc_cnt      <= TRFC_L;
      for (int unsigned b = 0; b < NB; b++) trcd_cnt[b] <= TRCD_L;
      refi_cnt      <= REFI_LIM;
      pend_q        <= '0;
      cl_o          <= 3'd3;
      bl_o          <= 4'd1;
      err_flags_o   <= '0;
      err_pulse_o   <= 1'b0;
      refresh_cnt_o <= '0;
    end else begin
      if (state_q == S_NOP) nop_cnt <= (cmd == C_NOP) ? nop_cnt + 1'b1 : '0;
      if (state_q == S_REF && cmd == C_REF && ref_cnt < REF_L) ref_cnt <= ref_cnt + 1'b1;

      if (cmd == C_PRE)         trp_cnt <= TRP_W'(1);
      else if (trp_cnt < TRP_L) trp_cnt <= trp_cnt + 1'b1;

      if (cmd == C_REF)           trfc_cnt <= TRFC_W'(1);
      else if (trfc_cnt < TRFC_L) trfc_cnt <= trfc_cnt + 1'b1;

      for (int unsigned b = 0; b < NB; b++) begin
        if (cmd == C_ACT && sdr_ba == BA_W'(b)) trcd_cnt[b] <= TRCD_W'(1);
        else if (trcd_cnt[b] < TRCD_L)          trcd_cnt[b] <= trcd_cnt[b] + 1'b1;
      end

      if (run_entry) refi_cnt <= '0;
      else if (state_q == S_RUN) begin
        if (cmd == C_REF)               refi_cnt <= '0;
        else if (refi_cnt != REFI_LIM)  refi_cnt <= refi_cnt + 1'b1;
      end

      pend_q <= {1'b0, pend_vec[WIN_N-1:1]};

      if (lmr_take) begin
        cl_o <= sdr_addr[6:4];
        case (sdr_addr[2:0])
          3'd1:    bl_o <= 4'd2;
          3'd2:    bl_o <= 4'd4;
          3'd3:    bl_o <= 4'd8;
          default: bl_o <= 4'd1;
        endcase
      end

      err_flags_o <= (err_clr_i ? 7'd0 : err_flags_o) | new_err;
      err_pulse_o <= |new_err;

      if (cmd == C_REF && refresh_cnt_o != 16'hFFFF) refresh_cnt_o <= refresh_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_sdram_cmd_monitor.sv
// Directed bench for sdram_cmd_monitor using default parameters.
module tb_sdram_cmd_monitor;

  localparam logic [3:0] K_NOP = 4'b0111, K_ACT = 4'b0011, K_RD  = 4'b0101,
                         K_WR  = 4'b0100, K_PRE = 4'b0010, K_REF = 4'b0001,
                         K_LMR = 4'b0000, K_BST = 4'b0110;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba;
  logic [12:0] addr;
  logic        rdv, clr;
  logic        init_done, pulse;
  logic [2:0]  cl;
  logic [3:0]  bl;
  logic [6:0]  flags;
  logic [15:0] rcnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sdram_cmd_monitor dut (
    .sdram_clk(clk), .sdram_resetn(resetn),
    .sdr_cs_n(cs_n), .sdr_ras_n(ras_n), .sdr_cas_n(cas_n), .sdr_we_n(we_n),
    .sdr_ba(ba), .sdr_addr(addr), .sdr_rd_valid(rdv), .err_clr_i(clr),
    .init_done_o(init_done), .cl_o(cl), .bl_o(bl), .err_flags_o(flags),
    .err_pulse_o(pulse), .refresh_cnt_o(rcnt)
  );

  task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
    {cs_n, ras_n, cas_n, we_n} = c;
    ba   = b;
    addr = a;
    @(posedge clk); #1;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) issue(K_NOP, 2'd0, 13'h000);
  endtask

  task automatic clear_flags();
    clr = 1'b1;
    nop(1);
    clr = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    nop(2);
    resetn = 1'b1;
  endtask

  task automatic do_init(input logic [12:0] mode);
    nop(100);
    issue(K_PRE, 2'd0, 13'h400);
    nop(2);
    issue(K_REF, 2'd0, 13'h000);
    nop(7);
    issue(K_REF, 2'd0, 13'h000);
    nop(7);
    issue(K_LMR, 2'd0, mode);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done got=%b exp=0", init_done); end
    checks++; if (cl !== 3'd3) begin errors++; $display("FAIL rst_cl got=%0d exp=3", cl); end
    checks++; if (bl !== 4'd1) begin errors++; $display("FAIL rst_bl got=%0d exp=1", bl); end
    checks++; if (flags !== 7'h00) begin errors++; $display("FAIL rst_flags got=%h exp=00", flags); end
    checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL rst_pulse got=%b exp=0", pulse); end
    checks++; if (rcnt !== 16'd0) begin errors++; $display("FAIL rst_refcnt got=%0d exp=0", rcnt); end
  endtask

  task automatic test_legal_init();
    do_reset();
    do_init(13'h033);
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done got=%b exp=1", init_done); end
    checks++; if (cl !== 3'd3) begin errors++; $display("FAIL init_cl got=%0d exp=3", cl); end
    checks++; if (bl !== 4'd8) begin errors++; $display("FAIL init_bl got=%0d exp=8", bl); end
    checks++; if (flags !== 7'h00) begin errors++; $display("FAIL init_flags got=%h exp=00", flags); end
    checks++; if (rcnt !== 16'd2) begin errors++; $display("FAIL init_refcnt got=%0d exp=2", rcnt); end
  endtask

  task automatic test_short_nop();
    do_reset();
    nop(50);
    issue(K_ACT, 2'd0, 13'h000);
    checks++; if (flags !== 7'h01) begin errors++; $display("FAIL shortnop_flags got=%h exp=01", flags); end
    checks++; if (pulse !== 1'b1) begin errors++; $display("FAIL shortnop_pulse got=%b exp=1", pulse); end
    nop(1);
    checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL shortnop_pulse_end got=%b exp=0", pulse); end
    checks++; if (flags !== 7'h01) begin errors++; $display("FAIL shortnop_sticky got=%h exp=01", flags); end
    clear_flags();
    checks++; if (flags !== 7'h00) begin errors++; $display("FAIL shortnop_clr got=%h exp=00", flags); end
  endtask

  task automatic test_bank_timing();
    do_reset();
    do_init(13'h033);
    issue(K_ACT, 2'd1, 13'h000);
    nop(1);
    issue(K_RD, 2'd1, 13'h000);
    checks++; if (flags !== 7'h04) begin errors++; $display("FAIL trcd_flags got=%h exp=04", flags); end
    checks++; if (pulse !== 1'b1) begin errors++; $display("FAIL trcd_pulse got=%b exp=1", pulse); end
    clear_flags();
    nop(1);
    rdv = 1'b1;
    nop(8);
    rdv = 1'b0;
    nop(2);
    checks++; if (flags !== 7'h00) begin errors++; $display("FAIL cl3bl8_window got=%h exp=00", flags); end
    issue(K_ACT, 2'd2, 13'h000);
    nop(2);
    issue(K_WR, 2'd2, 13'h000);
    checks++; if (flags !== 7'h00) begin errors++; $display("FAIL trcd_edge got=%h exp=00", flags); end
    issue(K_PRE, 2'd0, 13'h000);
    nop(1);
    issue(K_ACT, 2'd0, 13'h000);
    checks++; if (flags !== 7'h02) begin errors++; $display("FAIL trp_flags got=%h exp=02", flags); end
    issue(K_PRE, 2'd0, 13'h400);
    nop(2);
    issue(K_ACT, 2'd0, 13'h000);
    checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL trp_edge_pulse got=%b exp=0", pulse); end
    nop(3);
    issue(K_REF, 2'd0, 13'h000);
    nop(4);
    clr = 1'b1;
    issue(K_ACT, 2'd3, 13'h000);
    clr = 1'b0;
    checks++; if (flags !== 7'h08) begin errors++; $display("FAIL trfc_clr_same_cycle got=%h exp=08", flags); end
    clear_flags();
    issue(K_REF, 2'd0, 13'h000);
    nop(6);
    issue(K_ACT, 2'd3, 13'h000);
    checks++; if (flags !== 7'h00) begin errors++; $display("FAIL trfc_edge got=%h exp=00", flags); end
    checks++; if (rcnt !== 16'd4) begin errors++; $display("FAIL bank_refcnt got=%0d exp=4", rcnt); end
  endtask

  task automatic test_read_timing();
    do_reset();
    do_init(13'h022);
    checks++; if ({cl, bl} !== {3'd2, 4'd4}) begin errors++; $display("FAIL rd_mode got cl=%0d bl=%0d exp cl=2 bl=4", cl, bl); end
    rdv = 1'b0;
    issue(K_RD, 2'd0, 13'h000);
    nop(1);
    rdv = 1'b1;
    nop(4);
    rdv = 1'b0;
    nop(2);
    checks++; if (flags !== 7'h00) begin errors++; $display("FAIL rd_good got=%h exp=00", flags); end
    issue(K_RD, 2'd0, 13'h000);
    nop(2);
    checks++; if (flags !== 7'h40 || pulse !== 1'b1) begin errors++; $display("FAIL rd_late got flags=%h pulse=%b exp flags=40 pulse=1", flags, pulse); end
    rdv = 1'b1;
    nop(4);
    rdv = 1'b0;
    nop(2);
    checks++; if (flags !== 7'h40) begin errors++; $display("FAIL rd_late_sticky got=%h exp=40", flags); end
  endtask

  task automatic test_back_to_back();
    clear_flags();
    rdv = 1'b0;
    issue(K_RD, 2'd0, 13'h000);
    nop(1);
    rdv = 1'b1;
    issue(K_RD, 2'd0, 13'h000);
    nop(5);
    rdv = 1'b0;
    nop(2);
    checks++; if (flags !== 7'h00) begin errors++; $display("FAIL rd_b2b got=%h exp=00", flags); end
    issue(K_RD, 2'd0, 13'h000);
    issue(K_BST, 2'd0, 13'h000);
    rdv = 1'b1;
    nop(1);
    rdv = 1'b0;
    nop(4);
    checks++; if (flags !== 7'h00) begin errors++; $display("FAIL rd_bst got=%h exp=00", flags); end
  endtask

  task automatic test_refresh_interval();
    int pulses;
    do_reset();
    do_init(13'h033);
    nop(1560);
    checks++; if (flags !== 7'h00) begin errors++; $display("FAIL refi_early got=%h exp=00", flags); end
    nop(1);
    checks++; if (flags !== 7'h10 || pulse !== 1'b1) begin errors++; $display("FAIL refi_set got flags=%h pulse=%b exp flags=10 pulse=1", flags, pulse); end
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      nop(1);
      if (pulse === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL refi_once extra_pulses=%0d exp=0", pulses); end
    checks++; if (flags !== 7'h10) begin errors++; $display("FAIL refi_sticky got=%h exp=10", flags); end
    checks++; if (rcnt !== 16'd2) begin errors++; $display("FAIL refi_refcnt got=%0d exp=2", rcnt); end
  endtask

  task automatic test_illegal_cl_reset();
    clear_flags();
    issue(K_LMR, 2'd0, 13'h012);
    checks++; if (flags !== 7'h20) begin errors++; $display("FAIL clill_flags got=%h exp=20", flags); end
    checks++; if ({cl, bl} !== {3'd1, 4'd4}) begin errors++; $display("FAIL clill_mode got cl=%0d bl=%0d exp cl=1 bl=4", cl, bl); end
    resetn = 1'b0;
    nop(1);
    resetn = 1'b1;
    checks++; if ({init_done, cl, bl, flags, pulse, rcnt} !== {1'b0, 3'd3, 4'd1, 7'h00, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL midrst got done=%b cl=%0d bl=%0d flags=%h pulse=%b refcnt=%0d exp 0/3/1/00/0/0",
               init_done, cl, bl, flags, pulse, rcnt);
    end
  endtask

  initial begin
    resetn = 1'b0;
    {cs_n, ras_n, cas_n, we_n} = K_NOP;
    ba = 2'd0; addr = 13'h000; rdv = 1'b0; clr = 1'b0;
    #1;
    test_reset();
    test_legal_init();
    test_short_nop();
    test_bank_timing();
    test_read_timing();
    test_back_to_back();
    test_refresh_interval();
    test_illegal_cl_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
